vga_pixel_sweeper: RTL and testbench

VGA_PIXEL_SWEEPER -- requirements
Module: vga_pixel_sweeper

---
 rtl/vga_pixel_sweeper.sv | 119 +++++++++++
 tb/tb_vga_pixel_sweeper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_sweeper.sv
// Raster sweeper: snapshots reg_in, then strobes every pixel of an H_RES x V_RES frame once.
// Define VGA_SWEEPER_AUTO_REFRESH_EN for free-running back-to-back frames that ignore start.
module vga_pixel_sweeper #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  input  logic        stall,
  input  logic [31:0] reg_in,
  output logic [31:0] regs_snap,
  output logic [9:0]  draw_x,
  output logic [8:0]  draw_y,
  output logic        write,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {IDLE, SNAP, SWEEP, DONE} state_t;

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [31:0] snap_q, snap_d;
  logic [7:0]  fc_q, fc_d;
  logic        pend_q, pend_d;
  logic        last_px;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    snap_d  = snap_q;
    fc_d    = fc_q;
    pend_d  = pend_q;
    last_px = (x_q == X_LAST) && (y_q == Y_LAST);

`ifndef VGA_SWEEPER_AUTO_REFRESH_EN
    // Requests arriving while a frame is in flight collapse into one pending redraw.
    if (state_q != IDLE && start) pend_d = 1'b1;
`endif

    case (state_q)
      IDLE: begin
`ifdef VGA_SWEEPER_AUTO_REFRESH_EN
        state_d = SNAP;
`else
        if (start) state_d = SNAP;
`endif
      end
      SNAP: begin
        snap_d  = reg_in;
        x_d     = '0;
        y_d     = '0;
        state_d = SWEEP;
      end
      SWEEP: begin
        if (!stall) begin
          if (last_px) begin
            state_d = DONE;
          end else if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 9'd1;
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      DONE: begin
        fc_d = fc_q + 8'd1;
`ifdef VGA_SWEEPER_AUTO_REFRESH_EN
        state_d = SNAP;
`else
        // A start seen in this very cycle counts as pending too.
        if (pend_q || start) begin
          state_d = SNAP;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      snap_q  <= '0;
      fc_q    <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      snap_q  <= snap_d;
      fc_q    <= fc_d;
      pend_q  <= pend_d;
    end
  end

  // write tracks stall combinationally so a stalled pixel is never strobed.
  assign write       = (state_q == SWEEP) && !stall;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign draw_x      = x_q;
  assign draw_y      = y_q;
  assign regs_snap   = snap_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_pixel_sweeper.sv
// Bench for vga_pixel_sweeper at H_RES=4, V_RES=3: frame-sequence model plus directed scenarios.
module tb_vga_pixel_sweeper;
  localparam int H = 4;
  localparam int V = 3;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] reg_in = '0;
  logic [31:0] regs_snap;
  logic [9:0]  draw_x;
  logic [8:0]  draw_y;
  logic        write, busy, done;
  logic [7:0]  frame_count;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;

  vga_pixel_sweeper #(.H_RES(H), .V_RES(V)) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stall(stall), .reg_in(reg_in),
    .regs_snap(regs_snap), .draw_x(draw_x), .draw_y(draw_y), .write(write),
    .busy(busy), .done(done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame model: one step number walks -1 (idle), 0 (snapshot), 1..N (pixel N-1), N+1 (end of frame).
  int          m_step;
  bit          m_pend;
  logic [31:0] m_snap;
  logic [7:0]  m_fc;
  int          m_hx, m_hy;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_step = -1; m_pend = 0; m_snap = '0; m_fc = '0; m_hx = 0; m_hy = 0;
    end else begin
`ifndef VGA_SWEEPER_AUTO_REFRESH_EN
      if (m_step >= 0 && start) m_pend = 1;
`endif
      if (m_step < 0) begin
`ifdef VGA_SWEEPER_AUTO_REFRESH_EN
        m_step = 0;
`else
        if (start) m_step = 0;
`endif
      end else if (m_step == 0) begin
        m_snap = reg_in; m_hx = 0; m_hy = 0; m_step = 1;
      end else if (m_step <= N) begin
        if (!stall) begin
          if (m_step == N) begin m_hx = H - 1; m_hy = V - 1; end
          m_step++;
        end
      end else begin
        m_fc++;
`ifdef VGA_SWEEPER_AUTO_REFRESH_EN
        m_step = 0;
`else
        if (m_pend) begin m_step = 0; m_pend = 0; end
        else m_step = -1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      bit   e_sweep;
      int   ex, ey;
      e_sweep = (m_step >= 1) && (m_step <= N);
      ex = e_sweep ? (m_step - 1) % H : m_hx;
      ey = e_sweep ? (m_step - 1) / H : m_hy;
      chk("ctl_coords", {9'd0, busy, write, done, draw_x, draw_y},
          {9'd0, 1'(m_step >= 0), 1'(e_sweep && !stall), 1'(m_step == N + 1), 10'(ex), 9'(ey)});
      chk("frame_count", {24'd0, frame_count}, {24'd0, m_fc});
      chk("regs_snap", regs_snap, m_snap);
      if (write) wr_cnt++;
    end
  end

  task automatic do_frame(input bit do_stall, output int cyc);
    int st;
    bit stalled;
    st = 0; stalled = 0; cyc = 0;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (st > 0) begin
        chk("stall_hold", {12'd0, write, draw_x, draw_y}, {12'd0, 1'b0, 10'd2, 9'd1});
        st--;
        if (st == 0) stall = 1'b0;
      end else if (do_stall && !stalled && busy && draw_x == 10'd2 && draw_y == 9'd1) begin
        stall = 1'b1; stalled = 1; st = 3;
      end
      if (done) break;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, ndone;
    #1 resetn = 1'b0;
    #1;
    chk("rst_outs", {5'd0, busy, write, done, draw_x, draw_y, frame_count}, 32'd0);
    chk("rst_snap", regs_snap, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

`ifdef VGA_SWEEPER_AUTO_REFRESH_EN
    begin
      int t_last, gaps;
      t_last = -1; gaps = 0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (done) begin
          if (t_last >= 0) begin chk("auto_period", i - t_last, 14); gaps++; end
          t_last = i;
        end
      end
      chk("auto_frames", (gaps >= 4), 1);
    end
`else
    // Single frame
    reg_in = 32'h76543210;
    wr_cnt = 0;
    do_frame(0, cyc);
    chk("frame1_latency", cyc, 14);
    @(posedge clk); #1;
    chk("frame1_fc", {24'd0, frame_count}, 32'd1);
    chk("frame1_snap", regs_snap, 32'h76543210);
    chk("frame1_writes", wr_cnt, N);
    chk("frame1_idle", {30'd0, busy, done}, 32'd0);

    // Stall at (2,1) for 3 cycles
    wr_cnt = 0;
    do_frame(1, cyc);
    chk("stall_latency", cyc, 17);
    @(posedge clk); #1;
    chk("stall_fc", {24'd0, frame_count}, 32'd2);
    chk("stall_writes", wr_cnt, N);

    // Reset mid-frame at (1,1)
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy && write && draw_x == 10'd1 && draw_y == 9'd1) break;
    end
    chk("mid_reached", {12'd0, busy, draw_x, draw_y}, {12'd0, 1'b1, 10'd1, 9'd1});
    resetn = 1'b0;
    #1;
    chk("midrst_outs", {5'd0, busy, write, done, draw_x, draw_y, frame_count}, 32'd0);
    chk("midrst_snap", regs_snap, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_done", {31'd0, done}, 32'd0);
    end
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_idle", {23'd0, busy, frame_count}, 32'd0);

    // Coherency and collapsed pending requests
    wr_cnt = 0; ndone = 0;
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c >= 2 && ndone == 0) chk("snap_coherent", regs_snap, 32'h76543210);
      if (c == 4) begin reg_in = 32'hFFFFFFFF; start = 1'b1; end
      if (c == 7) start = 1'b1;
      if (done) ndone++;
      if (ndone == 2) break;
    end
    chk("pend_two_frames", ndone, 2);
    chk("pend_writes", wr_cnt, 2 * N);
    @(posedge clk); #1;
    chk("pend_fc", {24'd0, frame_count}, 32'd2);
    chk("pend_snap", regs_snap, 32'hFFFFFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("pend_no_third", {31'd0, busy}, 32'd0);

    // frame_count wrap over 256 frames
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int f = 0; f < 256; f++) begin
      do_frame(0, cyc);
      @(posedge clk); #1;
      if (f == 254) chk("wrap_255", {24'd0, frame_count}, 32'd255);
      if (f == 255) chk("wrap_0", {24'd0, frame_count}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
